// File: rtl/fwd_source_tracker_pkg.sv
// Shared types and constants for the forwarding-source tracker:
// register-number width, the per-stage field bundle and its bubble value.
package fwd_source_tracker_pkg;

    localparam int REG_W             = 4;
    localparam int MC_CYCLES_DEFAULT = 4;

    typedef struct packed {
        logic [REG_W-1:0] reg_op1;
        logic [REG_W-1:0] reg_op2;
        logic             reg_write;
        logic             mem_read;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    // Register 0 never produces a value, so it can never be a hazard source.
    function automatic logic src_match(input logic [REG_W-1:0] dest,
                                       input logic [REG_W-1:0] src_a,
                                       input logic [REG_W-1:0] src_b);
        return (dest != '0) && ((dest == src_a) || (dest == src_b));
    endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline stage register: bubble beats hold, hold beats load.
// A bubble is all-zero, which makes every register field and control bit 0.
module fwd_stage_reg
    import fwd_source_tracker_pkg::*;
#(
    parameter int W = 2 * REG_W + 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (bubble) begin
            data_d = '0;
        end else if (!hold) begin
            data_d = d_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_out = data_q;

endmodule

// File: rtl/fwd_source_tracker.sv
// Carries destination/RegWrite/MemRead through ID/EX, EX/MEM and MEM/WB and
// raises Stall for load-use and multi-cycle-execute hazards.
module fwd_source_tracker
    import fwd_source_tracker_pkg::*;
#(
    parameter int MC_CYCLES = MC_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_Valid,
    input  logic [REG_W-1:0] ID_RegisterOp1,
    input  logic [REG_W-1:0] ID_RegisterOp2,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             ID_MultiCycle,
    input  logic             Flush,
    output logic [REG_W-1:0] ID_EX_RegisterOp1,
    output logic [REG_W-1:0] ID_EX_RegisterOp2,
    output logic             ID_EX_RegWrite,
    output logic             ID_EX_MemRead,
    output logic [REG_W-1:0] EX_MEM_RegisterOp1,
    output logic             EX_MEM_RegWrite,
    output logic             EX_MEM_MemRead,
    output logic [REG_W-1:0] MEM_WB_RegisterOp1,
    output logic             MEM_WB_RegWrite,
    output logic             Stall,
    output logic             Busy
);

    localparam int CNT_W = $clog2(MC_CYCLES);
    localparam int IE_W  = 2 * REG_W + 2;
    localparam int EM_W  = REG_W + 2;
    localparam int MW_W  = REG_W + 1;

    stage_t           id_cap;
    stage_t           id_ex;
    logic [IE_W-1:0]  id_ex_bits;
    logic [EM_W-1:0]  ex_mem_bits;
    logic [MW_W-1:0]  mem_wb_bits;

    logic             load_use;
    logic             busy;
    logic             id_ex_hold;
    logic             id_ex_bubble;
    logic             ex_mem_bubble;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    assign id_ex = id_ex_bits;

    // Hazard detection and the stage-register steering it implies.
    always_comb begin
        id_cap = BUBBLE;
        if (ID_Valid) begin
            id_cap.reg_op1   = ID_RegisterOp1;
            id_cap.reg_op2   = ID_RegisterOp2;
            id_cap.reg_write = ID_RegWrite & (ID_RegisterOp1 != '0);
            id_cap.mem_read  = ID_MemRead;
        end

        busy     = (cnt_q != '0);
        load_use = ID_Valid & id_ex.mem_read & id_ex.reg_write &
                   src_match(id_ex.reg_op1, ID_RegisterOp1, ID_RegisterOp2);

        id_ex_hold    = busy;
        id_ex_bubble  = Flush | (~busy & load_use);
        ex_mem_bubble = busy;
    end

    // A multi-cycle op loads the counter only when it actually enters ID/EX.
    always_comb begin
        cnt_d = '0;
        if (Flush) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (ID_Valid & ID_MultiCycle & ~load_use) begin
            cnt_d = CNT_W'(MC_CYCLES - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    fwd_stage_reg #(.W(IE_W)) u_id_ex (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (id_ex_hold),
        .bubble (id_ex_bubble),
        .d_in   (id_cap),
        .q_out  (id_ex_bits)
    );

    fwd_stage_reg #(.W(EM_W)) u_ex_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (1'b0),
        .bubble (ex_mem_bubble),
        .d_in   ({id_ex.reg_op1, id_ex.reg_write, id_ex.mem_read}),
        .q_out  (ex_mem_bits)
    );

    fwd_stage_reg #(.W(MW_W)) u_mem_wb (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (1'b0),
        .bubble (1'b0),
        .d_in   (ex_mem_bits[EM_W-1:1]),
        .q_out  (mem_wb_bits)
    );

    assign ID_EX_RegisterOp1  = id_ex.reg_op1;
    assign ID_EX_RegisterOp2  = id_ex.reg_op2;
    assign ID_EX_RegWrite     = id_ex.reg_write;
    assign ID_EX_MemRead      = id_ex.mem_read;
    assign EX_MEM_RegisterOp1 = ex_mem_bits[EM_W-1:2];
    assign EX_MEM_RegWrite    = ex_mem_bits[1];
    assign EX_MEM_MemRead     = ex_mem_bits[0];
    assign MEM_WB_RegisterOp1 = mem_wb_bits[MW_W-1:1];
    assign MEM_WB_RegWrite    = mem_wb_bits[0];
    assign Stall              = ~Flush & (load_use | busy);
    assign Busy               = busy;

endmodule

// File: tb/tb_fwd_source_tracker.sv
// Directed scoreboard bench: each stimulus cycle queues the outputs expected
// during that cycle, and an independent monitor pops and compares them.
module tb_fwd_source_tracker;
    import fwd_source_tracker_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [3:0] id_op1 = '0;
    logic [3:0] id_op2 = '0;
    logic       id_rw = 1'b0;
    logic       id_mr = 1'b0;
    logic       id_mc = 1'b0;
    logic       flush = 1'b0;

    logic [3:0] ie_op1, ie_op2, em_op1, mw_op1;
    logic       ie_rw, ie_mr, em_rw, em_mr, mw_rw, stall, busy;

    typedef struct packed {
        logic       rst_n_v;
        logic       v;
        logic [3:0] o1;
        logic [3:0] o2;
        logic       rw;
        logic       mr;
        logic       mc;
        logic       fl;
    } in_t;

    typedef struct packed {
        logic [3:0] ie1;
        logic [3:0] ie2;
        logic       ierw;
        logic       iemr;
        logic [3:0] em1;
        logic       emrw;
        logic       emmr;
        logic [3:0] mw1;
        logic       mwrw;
        logic       stall;
        logic       busy;
    } out_t;

    typedef struct {
        string name;
        out_t  exp;
    } rec_t;

    rec_t exp_q[$];
    int   num_checks = 0;
    int   num_errors = 0;

    always #5 clk = ~clk;

    fwd_source_tracker #(.MC_CYCLES(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ID_Valid           (id_valid),
        .ID_RegisterOp1     (id_op1),
        .ID_RegisterOp2     (id_op2),
        .ID_RegWrite        (id_rw),
        .ID_MemRead         (id_mr),
        .ID_MultiCycle      (id_mc),
        .Flush              (flush),
        .ID_EX_RegisterOp1  (ie_op1),
        .ID_EX_RegisterOp2  (ie_op2),
        .ID_EX_RegWrite     (ie_rw),
        .ID_EX_MemRead      (ie_mr),
        .EX_MEM_RegisterOp1 (em_op1),
        .EX_MEM_RegWrite    (em_rw),
        .EX_MEM_MemRead     (em_mr),
        .MEM_WB_RegisterOp1 (mw_op1),
        .MEM_WB_RegWrite    (mw_rw),
        .Stall              (stall),
        .Busy               (busy)
    );

    function automatic in_t mk_in(input logic r, input logic v, input logic [3:0] o1,
                                  input logic [3:0] o2, input logic rw, input logic mr,
                                  input logic mc, input logic fl);
        in_t t;
        t.rst_n_v = r; t.v = v; t.o1 = o1; t.o2 = o2;
        t.rw = rw; t.mr = mr; t.mc = mc; t.fl = fl;
        return t;
    endfunction

    function automatic out_t mk_out(input logic [3:0] ie1, input logic [3:0] ie2,
                                    input logic ierw, input logic iemr,
                                    input logic [3:0] em1, input logic emrw, input logic emmr,
                                    input logic [3:0] mw1, input logic mwrw,
                                    input logic st, input logic bz);
        out_t t;
        t.ie1 = ie1; t.ie2 = ie2; t.ierw = ierw; t.iemr = iemr;
        t.em1 = em1; t.emrw = emrw; t.emmr = emmr;
        t.mw1 = mw1; t.mwrw = mwrw; t.stall = st; t.busy = bz;
        return t;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("IE(%0d,%0d,rw%0b,mr%0b) EM(%0d,rw%0b,mr%0b) MW(%0d,rw%0b) stall=%0b busy=%0b",
                         o.ie1, o.ie2, o.ierw, o.iemr, o.em1, o.emrw, o.emmr,
                         o.mw1, o.mwrw, o.stall, o.busy);
    endfunction

    // Inputs change on the falling edge; the expectation covers that whole cycle.
    task automatic applyStimulus(input string name, input in_t s, input out_t e);
        rec_t r;
        @(negedge clk);
        rst_n    = s.rst_n_v;
        id_valid = s.v;
        id_op1   = s.o1;
        id_op2   = s.o2;
        id_rw    = s.rw;
        id_mr    = s.mr;
        id_mc    = s.mc;
        flush    = s.fl;
        r.name   = name;
        r.exp    = e;
        exp_q.push_back(r);
    endtask

    task automatic checkOutput(input string name, input out_t e);
        out_t a;
        a = mk_out(ie_op1, ie_op2, ie_rw, ie_mr, em_op1, em_rw, em_mr,
                   mw_op1, mw_rw, stall, busy);
        num_checks++;
        if (a !== e) begin
            num_errors++;
            $display("[TB] FAIL %s: got %s, expected %s", name, fmt(a), fmt(e));
        end
    endtask

    // Monitor: sample mid-low-phase, well clear of the rising edge.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                checkOutput(r.name, r.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_t  nop;
        out_t z;
        nop = mk_in(1, 0, 0, 0, 0, 0, 0, 0);
        z   = '0;

        applyStimulus("reset_state",   mk_in(0, 0, 0, 0, 0, 0, 0, 0), z);
        applyStimulus("add_issue",     mk_in(1, 1, 3, 1, 1, 0, 0, 0), z);
        applyStimulus("add_in_ex",     nop, mk_out(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus("add_in_mem",    nop, mk_out(0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0));
        applyStimulus("add_in_wb",     nop, mk_out(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));

        applyStimulus("load_r5",       mk_in(1, 1, 5, 2, 1, 1, 0, 0), z);
        applyStimulus("lu_stall_op1",  mk_in(1, 1, 5, 2, 1, 0, 0, 0), mk_out(5, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0));
        applyStimulus("lu_bubble",     mk_in(1, 1, 5, 2, 1, 0, 0, 0), mk_out(0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0));
        applyStimulus("lu_add_in_ex",  nop, mk_out(5, 2, 1, 0, 0, 0, 0, 5, 1, 0, 0));
        applyStimulus("lu_add_in_mem", nop, mk_out(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0));

        applyStimulus("load_r0",       mk_in(1, 1, 0, 1, 1, 1, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0));
        applyStimulus("r0_no_stall",   mk_in(1, 1, 0, 1, 1, 0, 0, 0), mk_out(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus("r0_add_in_ex",  nop, mk_out(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        applyStimulus("load_r6",       mk_in(1, 1, 6, 2, 1, 1, 0, 0), z);
        applyStimulus("lu_stall_op2",  mk_in(1, 1, 7, 6, 1, 0, 0, 0), mk_out(6, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0));
        applyStimulus("lu2_bubble",    nop, mk_out(0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0));
        applyStimulus("load_r9",       mk_in(1, 1, 9, 2, 1, 1, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0));
        applyStimulus("no_match",      mk_in(1, 1, 7, 8, 1, 0, 0, 0), mk_out(9, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus("no_match_ex",   nop, mk_out(7, 8, 1, 0, 9, 1, 1, 0, 0, 0, 0));
        applyStimulus("no_match_mem",  nop, mk_out(0, 0, 0, 0, 7, 1, 0, 9, 1, 0, 0));
        applyStimulus("no_match_wb",   nop, mk_out(0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0));

        applyStimulus("mul_issue",     mk_in(1, 1, 4, 2, 1, 0, 1, 0), z);
        applyStimulus("mul_busy1",     mk_in(1, 1, 1, 2, 1, 0, 0, 0), mk_out(4, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1));
        applyStimulus("mul_busy2",     mk_in(1, 1, 1, 2, 1, 0, 0, 0), mk_out(4, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1));
        applyStimulus("mul_busy3",     mk_in(1, 1, 1, 2, 1, 0, 0, 0), mk_out(4, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1));
        applyStimulus("mul_last_ex",   mk_in(1, 1, 1, 2, 1, 0, 0, 0), mk_out(4, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus("mul_in_mem",    nop, mk_out(1, 2, 1, 0, 4, 1, 0, 0, 0, 0, 0));
        applyStimulus("mul_in_wb",     nop, mk_out(0, 0, 0, 0, 1, 1, 0, 4, 1, 0, 0));
        applyStimulus("add_after_mul", nop, mk_out(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));

        applyStimulus("mul2_issue",    mk_in(1, 1, 8, 3, 1, 0, 1, 0), z);
        applyStimulus("mul2_busy",     nop, mk_out(8, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1));
        applyStimulus("flush_busy",    mk_in(1, 0, 0, 0, 0, 0, 0, 1), mk_out(8, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        applyStimulus("after_flush",   nop, z);
        applyStimulus("add_r2",        mk_in(1, 1, 2, 3, 1, 0, 0, 0), z);
        applyStimulus("flush_idle",    mk_in(1, 1, 5, 6, 1, 0, 0, 1), mk_out(2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus("flush_passes",  nop, mk_out(0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));

        applyStimulus("fill_add",      mk_in(1, 1, 10, 11, 1, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        applyStimulus("fill_load",     mk_in(1, 1, 12, 1, 1, 1, 0, 0), mk_out(10, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus("fill_mul",      mk_in(1, 1, 13, 2, 1, 0, 1, 0), mk_out(12, 1, 1, 1, 10, 1, 0, 0, 0, 0, 0));
        applyStimulus("fill_busy1",    nop, mk_out(13, 2, 1, 0, 12, 1, 1, 10, 1, 1, 1));
        applyStimulus("fill_busy2",    nop, mk_out(13, 2, 1, 0, 0, 0, 0, 12, 1, 1, 1));
        applyStimulus("async_reset",   mk_in(0, 1, 13, 13, 1, 0, 0, 0), z);
        applyStimulus("reset_hold",    mk_in(0, 0, 0, 0, 0, 0, 0, 0), z);
        applyStimulus("reset_release", nop, z);
        applyStimulus("post_reset",    nop, z);

        @(negedge clk);
        #5;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            #5;
        end
        if (exp_q.size() > 0) begin
            num_errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
